// File: rtl/uop_sched_pkg.sv
// rtl/uop_sched_pkg.sv - shared entry type, default sizes and width helpers for the uop scheduler
package uop_sched_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_UOP_W = 32;
  localparam int DEF_TAG_W = 6;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Entry field widths follow the default UOP_W/TAG_W constants.
  typedef struct packed {
    logic                 valid;
    logic [DEF_UOP_W-1:0] uop;
    logic [DEF_TAG_W-1:0] dst_tag;
    logic [DEF_TAG_W-1:0] src1_tag;
    logic                 src1_rdy;
    logic [DEF_TAG_W-1:0] src2_tag;
    logic                 src2_rdy;
  } sched_entry_t;

endpackage

// File: rtl/uop_age_matrix.sv
// rtl/uop_age_matrix.sv - older-than bit matrix picking the oldest requesting entry
module uop_age_matrix
  import uop_sched_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] grant_o
);

  // older_q[i][j] set means entry i was allocated before entry j.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      older_d[i] = older_q[i];
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (free_i[k]) begin
        older_d[k] = '0;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (alloc_i[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          older_d[i][k] = (i != k);
        end
        older_d[k] = '0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      grant_o[i] = req_i[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && req_i[j] && older_q[j][i]) begin
          grant_o[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset || clear_i) begin
        older_q[i] <= '0;
      end else begin
        older_q[i] <= older_d[i];
      end
    end
  end

endmodule

// File: rtl/uop_issue_sched.sv
// rtl/uop_issue_sched.sv - age-ordered issue scheduler with tag wakeup and registered output
// Optional: define UOP_ISSUE_SCHED_SELF_WAKEUP_EN to broadcast the issued dst tag as a wakeup.
module uop_issue_sched
  import uop_sched_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int UOP_W = DEF_UOP_W,
  parameter int TAG_W = DEF_TAG_W,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enabled,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [UOP_W-1:0] in_uop,
  input  logic [TAG_W-1:0] in_dst_tag,
  input  logic [TAG_W-1:0] in_src1_tag,
  input  logic             in_src1_rdy,
  input  logic [TAG_W-1:0] in_src2_tag,
  input  logic             in_src2_rdy,
  input  logic             wakeup_valid,
  input  logic [TAG_W-1:0] wakeup_tag,
  output logic             out_valid,
  output logic [UOP_W-1:0] out_uop,
  output logic [TAG_W-1:0] out_dst_tag,
  input  logic             next_stalled,
  output logic [CNT_W-1:0] count
);

  sched_entry_t     ent_q [DEPTH];
  sched_entry_t     ent_d [DEPTH];
  logic [DEPTH-1:0] cand, grant, alloc_oh, free_oh;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [UOP_W-1:0] out_uop_q, out_uop_d;
  logic [TAG_W-1:0] out_dst_q, out_dst_d;
  logic             alloc, fire, out_free;
  logic [UOP_W-1:0] gnt_uop;
  logic [TAG_W-1:0] gnt_dst;
  logic             wk2_valid;
  logic [TAG_W-1:0] wk2_tag;

  assign in_ready = !reset && enabled && !clear && (count_q < CNT_W'(DEPTH));
  assign alloc    = in_valid && in_ready;
  assign out_free = !out_valid_q || !next_stalled;
  assign fire     = enabled && !clear && out_free && (|grant);
  assign free_oh  = grant & {DEPTH{fire}};

  // Descending scan so the lowest free index wins.
  always_comb begin
    alloc_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        alloc_oh    = '0;
        alloc_oh[i] = alloc;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
    end
  end

  uop_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear),
    .alloc_i (alloc_oh),
    .free_i  (free_oh),
    .req_i   (cand),
    .grant_o (grant)
  );

  always_comb begin
    gnt_uop = '0;
    gnt_dst = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        gnt_uop |= ent_q[i].uop;
        gnt_dst |= ent_q[i].dst_tag;
      end
    end
  end

`ifdef UOP_ISSUE_SCHED_SELF_WAKEUP_EN
  assign wk2_valid = fire;
  assign wk2_tag   = gnt_dst;
`else
  assign wk2_valid = 1'b0;
  assign wk2_tag   = '0;
`endif

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if ((wakeup_valid && wakeup_tag == ent_q[i].src1_tag) ||
          (wk2_valid && wk2_tag == ent_q[i].src1_tag)) begin
        ent_d[i].src1_rdy = 1'b1;
      end
      if ((wakeup_valid && wakeup_tag == ent_q[i].src2_tag) ||
          (wk2_valid && wk2_tag == ent_q[i].src2_tag)) begin
        ent_d[i].src2_rdy = 1'b1;
      end
      if (free_oh[i]) begin
        ent_d[i].valid = 1'b0;
      end
      if (alloc_oh[i]) begin
        ent_d[i].valid    = 1'b1;
        ent_d[i].uop      = in_uop;
        ent_d[i].dst_tag  = in_dst_tag;
        ent_d[i].src1_tag = in_src1_tag;
        ent_d[i].src2_tag = in_src2_tag;
        ent_d[i].src1_rdy = in_src1_rdy || (wakeup_valid && wakeup_tag == in_src1_tag) ||
                            (wk2_valid && wk2_tag == in_src1_tag);
        ent_d[i].src2_rdy = in_src2_rdy || (wakeup_valid && wakeup_tag == in_src2_tag) ||
                            (wk2_valid && wk2_tag == in_src2_tag);
      end
      if (clear) begin
        ent_d[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_uop_d   = out_uop_q;
    out_dst_d   = out_dst_q;
    count_d     = count_q + CNT_W'(alloc) - CNT_W'(fire);
    if (clear) begin
      out_valid_d = 1'b0;
      count_d     = '0;
    end else if (fire) begin
      out_valid_d = 1'b1;
      out_uop_d   = gnt_uop;
      out_dst_d   = gnt_dst;
    end else if (enabled && out_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_uop_q   <= '0;
      out_dst_q   <= '0;
      count_q     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      out_valid_q <= out_valid_d;
      out_uop_q   <= out_uop_d;
      out_dst_q   <= out_dst_d;
      count_q     <= count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_uop     = out_uop_q;
  assign out_dst_tag = out_dst_q;
  assign count       = count_q;

endmodule

// File: tb/tb_uop_issue_sched.sv
// tb/tb_uop_issue_sched.sv - randomized scoreboard bench for uop_issue_sched against a queue model
module tb_uop_issue_sched;

  localparam int DEPTH = 8;
  localparam int UOP_W = 32;
  localparam int TAG_W = 6;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset, clear, enabled, in_valid, in_ready;
  logic [UOP_W-1:0] in_uop, out_uop;
  logic [TAG_W-1:0] in_dst_tag, in_src1_tag, in_src2_tag, wakeup_tag, out_dst_tag;
  logic             in_src1_rdy, in_src2_rdy, wakeup_valid, out_valid, next_stalled;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  uop_issue_sched #(.DEPTH(DEPTH), .UOP_W(UOP_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .enabled(enabled),
    .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop), .in_dst_tag(in_dst_tag),
    .in_src1_tag(in_src1_tag), .in_src1_rdy(in_src1_rdy),
    .in_src2_tag(in_src2_tag), .in_src2_rdy(in_src2_rdy),
    .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag),
    .out_valid(out_valid), .out_uop(out_uop), .out_dst_tag(out_dst_tag),
    .next_stalled(next_stalled), .count(count)
  );

  // Reference: pending uops kept in a list in arrival order; oldest ready one issues.
  typedef struct {
    logic [UOP_W-1:0] uop;
    logic [TAG_W-1:0] dst, t1, t2;
    logic             r1, r2;
  } m_ent_t;
  typedef struct {
    logic [UOP_W-1:0] uop;
    logic [TAG_W-1:0] dst;
  } beat_t;

  m_ent_t mq[$];
  beat_t  sb[$];
  beat_t  b;
  logic   m_ov = 1'b0;
  int     total = 0;
  int     bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic woke(input logic [TAG_W-1:0] t, input logic sw, input logic [TAG_W-1:0] swt);
    return (wakeup_valid && wakeup_tag == t) || (sw && swt == t);
  endfunction

  task automatic model_step(input logic exp_rdy);
    int g;
    logic fire, sw;
    logic [TAG_W-1:0] swt;
    if (clear) begin
      mq.delete();
      sb.delete();
      m_ov = 1'b0;
      return;
    end
    g = -1;
    foreach (mq[i]) if (g < 0 && mq[i].r1 && mq[i].r2) g = i;
    fire = enabled && (!m_ov || !next_stalled) && (g >= 0);
    sw  = 1'b0;
    swt = '0;
`ifdef UOP_ISSUE_SCHED_SELF_WAKEUP_EN
    if (fire) begin
      sw  = 1'b1;
      swt = mq[g].dst;
    end
`endif
    foreach (mq[i]) begin
      if (woke(mq[i].t1, sw, swt)) mq[i].r1 = 1'b1;
      if (woke(mq[i].t2, sw, swt)) mq[i].r2 = 1'b1;
    end
    if (fire) begin
      sb.push_back('{uop: mq[g].uop, dst: mq[g].dst});
      mq.delete(g);
      m_ov = 1'b1;
    end else if (enabled && !next_stalled) begin
      m_ov = 1'b0;
    end
    if (in_valid && exp_rdy) begin
      mq.push_back('{uop: in_uop, dst: in_dst_tag, t1: in_src1_tag, t2: in_src2_tag,
                     r1: in_src1_rdy || woke(in_src1_tag, sw, swt),
                     r2: in_src2_rdy || woke(in_src2_tag, sw, swt)});
    end
  endtask

  task automatic run_phase(input int n, input int pv, input int pr, input int pw,
                           input int ps, input int pe, input int pc, input bit sweep);
    logic exp_rdy;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      in_valid     = ($urandom_range(0, 99) < pv);
      in_uop       = $urandom();
      in_dst_tag   = TAG_W'($urandom_range(0, 7));
      in_src1_tag  = TAG_W'($urandom_range(0, 7));
      in_src2_tag  = TAG_W'($urandom_range(0, 7));
      in_src1_rdy  = ($urandom_range(0, 99) < pr);
      in_src2_rdy  = ($urandom_range(0, 99) < pr);
      wakeup_valid = sweep ? 1'b1 : ($urandom_range(0, 99) < pw);
      wakeup_tag   = sweep ? TAG_W'(c % 8) : TAG_W'($urandom_range(0, 7));
      next_stalled = ($urandom_range(0, 99) < ps);
      enabled      = ($urandom_range(0, 99) < pe);
      clear        = ($urandom_range(0, 99) < pc);
      #1;
      exp_rdy = enabled && !clear && (mq.size() < DEPTH);
      check("count", 64'(count), 64'(mq.size()));
      check("out_valid", 64'(out_valid), 64'(m_ov));
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      model_step(exp_rdy);
    end
  endtask

  // Monitor: a beat is consumed at the coming edge when it is presented and not held.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid && !next_stalled && enabled && !clear) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got beat %0h expected none at %0t", out_uop, $time);
        end else begin
          b = sb.pop_front();
          check("out_uop", 64'(out_uop), 64'(b.uop));
          check("out_dst_tag", 64'(out_dst_tag), 64'(b.dst));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0; enabled = 1'b1; in_valid = 1'b1;
    in_uop = 32'hA; in_dst_tag = '0; in_src1_tag = '0; in_src2_tag = '0;
    in_src1_rdy = 1'b1; in_src2_rdy = 1'b1; wakeup_valid = 1'b0; wakeup_tag = '0;
    next_stalled = 1'b0;
    #1;
    check("in_ready_during_reset", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("reset_count", 64'(count), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_uop", 64'(out_uop), 64'd0);
    check("reset_out_dst_tag", 64'(out_dst_tag), 64'd0);
    check("in_ready_reset_held", 64'(in_ready), 64'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    run_phase(300, 60, 50, 40, 30, 90, 2, 1'b0);
    run_phase(200, 70, 30, 30, 70, 100, 0, 1'b0);
    run_phase(30, 100, 0, 0, 0, 100, 0, 1'b0);
    run_phase(200, 50, 50, 50, 40, 60, 5, 1'b0);
    run_phase(30, 100, 0, 0, 100, 100, 0, 1'b0);
    run_phase(100, 0, 0, 100, 0, 100, 0, 1'b1);
    @(negedge clk);
    #3;
    check("drain_count", 64'(count), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
